// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: opcodes, FSM encoding and opcode legality shared by the MAC scheduler.
package mac_sched_pkg;
    localparam logic [2:0] OP_SQ      = 3'd0;
    localparam logic [2:0] OP_SC      = 3'd1;
    localparam logic [2:0] OP_MAT8    = 3'd2;
    localparam logic [2:0] OP_MAT16   = 3'd3;
    localparam logic [2:0] OP_COL_SUM = 3'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_COL_SUM;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after rr_ptr.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
    always_comb begin
        idx = '0;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(rr_ptr) + k) % NREQ]) idx = IW'((int'(rr_ptr) + k) % NREQ);
    end

    assign any = |req;
    assign gnt = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin sharing of the single MAC datapath among NREQ client engines.
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int RES_W   = 24,
    parameter int TIMEOUT = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] op,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   job_done,
    output logic [NREQ-1:0]   job_err,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              mac_sq,
    output logic              mac_sc,
    output logic              mac_mat8,
    output logic              mac_mat16,
    output logic              mac_col_sum,
    input  logic              mac_done,
    input  logic [RES_W-1:0]  mac_out
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n, rr_ptr, ptr_n, arb_idx;
    logic [2:0]       op_q, op_n, op_sel;
    logic [CW-1:0]    cnt, cnt_n;
    logic [NREQ-1:0]  arb_gnt, gnt_n, done_n, err_n;
    logic             arb_any;
    logic [4:0]       strb, strb_n;
    logic [RES_W-1:0] res_n;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(req), .rr_ptr(rr_ptr), .gnt(arb_gnt), .idx(arb_idx), .any(arb_any)
    );

    assign op_sel = op[3*arb_idx +: 3];
    assign {mac_col_sum, mac_mat16, mac_mat8, mac_sc, mac_sq} = strb;

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        op_n    = op_q;
        cnt_n   = cnt;
        ptr_n   = rr_ptr;
        gnt_n   = gnt;
        done_n  = '0;
        err_n   = '0;
        strb_n  = '0;
        res_n   = result;
        unique case (state)
            IDLE: if (arb_any) begin
                state_n = ISSUE;
                idx_n   = arb_idx;
                op_n    = op_sel;
                gnt_n   = arb_gnt;
                strb_n  = op_legal(op_sel) ? 5'(1) << op_sel : '0;
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = op_legal(op_q) ? WAIT : RESP;
                err_n   = op_legal(op_q) ? '0 : gnt;
            end
            WAIT: begin
                cnt_n = cnt + 1'b1;
                if (mac_done) begin
                    state_n = RESP;
                    res_n   = mac_out;
                    done_n  = gnt;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    err_n   = gnt;
                end
            end
            RESP: begin
                state_n = IDLE;
                ptr_n   = idx;
                gnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            rr_ptr   <= IW'(NREQ - 1);
            gnt      <= '0;
            job_done <= '0;
            job_err  <= '0;
            strb     <= '0;
            result   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            op_q     <= op_n;
            cnt      <= cnt_n;
            rr_ptr   <= ptr_n;
            gnt      <= gnt_n;
            job_done <= done_n;
            job_err  <= err_n;
            strb     <= strb_n;
            result   <= res_n;
            busy     <= state_n != IDLE;
        end
    end
endmodule

// File: doc/mac_scheduler.md
# mac_scheduler

Round-robin scheduler sharing the single MAC datapath among NREQ client units (squash, routing-coefficient, matrix and column-sum engines). Accepts one operation request per client, drives exactly one MAC start strobe (sq/sc/mat8/mat16/col_sum), waits for the MAC `done`, captures the 24-bit result and returns a completion or error pulse to the granted client. Sits between the client engines and the MAC top level; the MAC's own controller still owns the 8/16/1152 counters.

## Interface
- NREQ, 3: number of requesting clients (2..8).
- RES_W, 24: MAC result width.
- TIMEOUT, 2047: max cycles in WAIT before abort. Must exceed the longest MAC job (1152-term accumulation).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-client request level.
- op  in  3*NREQ  per-client opcode, client i at [3i+2:3i]. 0=SQ, 1=SC, 2=MAT8, 3=MAT16, 4=COL_SUM, 5..7 illegal.
- gnt  out  NREQ  one-hot grant, held for the whole job.
- job_done  out  NREQ  one-cycle success pulse to the granted client.
- job_err  out  NREQ  one-cycle error pulse (illegal op or timeout).
- result  out  RES_W  captured MAC output, held until the next capture.
- busy  out  1  high in any state other than IDLE.
- mac_sq, mac_sc, mac_mat8, mac_mat16, mac_col_sum  out  1 each  MAC start strobes, one-hot, one cycle.
- mac_done  in  1  MAC completion.
- mac_out  in  RES_W  MAC result, valid with mac_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, choose the first requester after rr_ptr, cyclically.
  - Register the winner index and its op.
  - Go to ISSUE.
- ISSUE:
  - gnt[idx] is asserted.
  - For a legal op: pulse the matching mac_* strobe, clear the timeout counter, go to WAIT.
  - For an illegal op: no strobe, set err_flag, go to RESP.
- WAIT:
  - Counter increments each cycle.
  - On mac_done: result <= mac_out, go to RESP.
  - Else, when the counter reaches TIMEOUT: set err_flag, go to RESP. result is unchanged.
- RESP:
  - Pulse job_done[idx], or job_err[idx] if err_flag.
  - rr_ptr <= idx. Clear err_flag. Go to IDLE.
  - gnt drops on the next cycle.
- req is sampled only in IDLE. Dropping req mid-job does not abort the job.
- A client must drop or re-validate req on the cycle after its job_done. If req is still high, it is treated as a new request.
- mac_done in IDLE, ISSUE or RESP is ignored.
- If mac_done coincides with the TIMEOUT cycle, mac_done wins: success, result captured.
- op is sampled once, in IDLE. Later changes have no effect on the running job.

## Timing
- Reset (rst=0, async):
  - State IDLE; gnt, job_done, job_err, busy and all mac_* = 0.
  - result = 0; counter = 0.
  - rr_ptr = NREQ-1, so client 0 has first priority.
- Reset asserted mid-job aborts silently with no pulse to the client. The MAC is reset by the same rst at top level.
- Latencies:
  - req seen in IDLE at cycle t: gnt and the strobe at t+1.
  - mac_done at cycle d: result and job_done valid at d+1; gnt low at d+2.
  - Minimum job (mac_done in the first WAIT cycle t+2): 4 cycles from IDLE back to IDLE.
  - Illegal op: job_err at t+2.
  - Timeout: job_err at cycle t+2+TIMEOUT.
- All outputs are registered. No combinational path from req or mac_done to any output.

## Structure
- Package mac_sched_pkg holds:
  - Opcode localparams OP_SQ..OP_COL_SUM.
  - State encoding.
  - Function op_legal().
- Sub-module rr_arbiter (NREQ):
  - Combinational masked priority pick.
  - Inputs: req, rr_ptr. Outputs: one-hot grant, index, any.
- FSM, counter and strobe decode live in mac_scheduler.

## Test plan
- Single job: client 1 op=2 (MAT8). Model returns mac_done with mac_out=24'h00ABCD 8 cycles after the strobe -> mac_mat8 for one cycle, gnt=3'b010 throughout the job, job_done[1] one cycle after mac_done, result=24'h00ABCD.
- Contention: all three clients request continuously with op=0 -> grant order 0,1,2,0,1,2. Exactly one mac_sq per job; never two strobes in the same cycle.
- Illegal op: client 2 op=6 -> no mac_* strobe, job_err[2] at t+2, result unchanged.
- Timeout: TIMEOUT=15, mac_done never asserted -> job_err on cycle t+17, busy low on the following cycle.
- Reset mid-WAIT: drop rst for 1 cycle during a MAT16 job -> all outputs 0 immediately. Next request from client 0 is granted first.
- Boundaries:
  - Stray mac_done in IDLE -> no pulse.
  - mac_done on the TIMEOUT cycle -> job_done, not job_err.
